// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It forwards operands from EX/MEM/WB at capture time,
// inserts a one-cycle bubble on a load-use hazard, and drives the ALU directly.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imme,
   input  logic [4:0]        id_shamt,
   input  logic [3:0]        id_alu_control,
   input  logic              id_alu_src,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              load_use_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_data_a,
   output logic [DATA_W-1:0] ex_data_b,
   output logic [15:0]       ex_imme,
   output logic [4:0]        ex_shamt,
   output logic [3:0]        ex_alu_control,
   output logic              ex_alu_src,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write
);

   logic              ex_valid_r;
   logic [DATA_W-1:0] ex_data_a_r;
   logic [DATA_W-1:0] ex_data_b_r;
   logic [15:0]       ex_imme_r;
   logic [4:0]        ex_shamt_r;
   logic [3:0]        ex_alu_control_r;
   logic              ex_alu_src_r;
   logic [REG_AW-1:0] ex_rd_r;
   logic              ex_reg_write_r;
   logic              ex_mem_read_r;
   logic              ex_mem_write_r;

   logic              uses_rt_s;
   logic              stall_s;
   logic              ex_fwd_en_s;
   logic              bubble_s;
   logic [DATA_W-1:0] fwd_a_s;
   logic [DATA_W-1:0] fwd_b_s;

   // Priority mux EX > MEM > WB > register file; r0 never forwards.
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic [DATA_W-1:0] rf_data,
      input logic              ex_en,
      input logic [REG_AW-1:0] ex_dst,
      input logic [DATA_W-1:0] ex_val,
      input logic              mem_en,
      input logic [REG_AW-1:0] mem_dst,
      input logic [DATA_W-1:0] mem_val,
      input logic              wb_en,
      input logic [REG_AW-1:0] wb_dst,
      input logic [DATA_W-1:0] wb_val
   );
      logic [DATA_W-1:0] res;
      if (src == {REG_AW{1'b0}}) begin
         res = rf_data;
      end else if (ex_en && (ex_dst == src)) begin
         res = ex_val;
      end else if (mem_en && (mem_dst == src)) begin
         res = mem_val;
      end else if (wb_en && (wb_dst == src)) begin
         res = wb_val;
      end else begin
         res = rf_data;
      end
      return res;
   endfunction

   // Hazard detection and operand forwarding for the instruction in ID.
   always_comb begin
      uses_rt_s   = (~id_alu_src) | id_mem_write;
      stall_s     = id_valid & ex_valid_r & ex_mem_read_r &
                    (ex_rd_r != {REG_AW{1'b0}}) &
                    ((ex_rd_r == id_rs) | (uses_rt_s & (ex_rd_r == id_rt)));
      // A held load has no result yet, so it can only be forwarded from MEM.
      ex_fwd_en_s = ex_valid_r & ex_reg_write_r & ~ex_mem_read_r;
      bubble_s    = flush | ((~hold) & stall_s);
      fwd_a_s     = fwd_sel(id_rs, id_rs_data, ex_fwd_en_s, ex_rd_r, ex_alu_result,
                            mem_reg_write, mem_rd, mem_data, wb_reg_write, wb_rd, wb_data);
      fwd_b_s     = fwd_sel(id_rt, id_rt_data, ex_fwd_en_s, ex_rd_r, ex_alu_result,
                            mem_reg_write, mem_rd, mem_data, wb_reg_write, wb_rd, wb_data);
   end

   // ID/EX register: flush beats hold, hold beats the load-use bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_r       <= 1'b0;
         ex_data_a_r      <= {DATA_W{1'b0}};
         ex_data_b_r      <= {DATA_W{1'b0}};
         ex_imme_r        <= 16'h0000;
         ex_shamt_r       <= 5'd0;
         ex_alu_control_r <= 4'h0;
         ex_alu_src_r     <= 1'b0;
         ex_rd_r          <= {REG_AW{1'b0}};
         ex_reg_write_r   <= 1'b0;
         ex_mem_read_r    <= 1'b0;
         ex_mem_write_r   <= 1'b0;
      end else if (bubble_s) begin
         ex_valid_r       <= 1'b0;
         ex_data_a_r      <= {DATA_W{1'b0}};
         ex_data_b_r      <= {DATA_W{1'b0}};
         ex_imme_r        <= 16'h0000;
         ex_shamt_r       <= 5'd0;
         ex_alu_control_r <= 4'h0;
         ex_alu_src_r     <= 1'b0;
         ex_rd_r          <= {REG_AW{1'b0}};
         ex_reg_write_r   <= 1'b0;
         ex_mem_read_r    <= 1'b0;
         ex_mem_write_r   <= 1'b0;
      end else if (hold) begin
         ex_valid_r       <= ex_valid_r;
         ex_data_a_r      <= ex_data_a_r;
         ex_data_b_r      <= ex_data_b_r;
         ex_imme_r        <= ex_imme_r;
         ex_shamt_r       <= ex_shamt_r;
         ex_alu_control_r <= ex_alu_control_r;
         ex_alu_src_r     <= ex_alu_src_r;
         ex_rd_r          <= ex_rd_r;
         ex_reg_write_r   <= ex_reg_write_r;
         ex_mem_read_r    <= ex_mem_read_r;
         ex_mem_write_r   <= ex_mem_write_r;
      end else begin
         ex_valid_r       <= id_valid;
         ex_data_a_r      <= fwd_a_s;
         ex_data_b_r      <= fwd_b_s;
         ex_imme_r        <= id_imme;
         ex_shamt_r       <= id_shamt;
         ex_alu_control_r <= id_alu_control;
         ex_alu_src_r     <= id_alu_src;
         ex_rd_r          <= id_rd;
         ex_reg_write_r   <= id_reg_write;
         ex_mem_read_r    <= id_mem_read;
         ex_mem_write_r   <= id_mem_write;
      end
   end

   assign load_use_stall = stall_s;
   assign ex_valid       = ex_valid_r;
   assign ex_data_a      = ex_data_a_r;
   assign ex_data_b      = ex_data_b_r;
   assign ex_imme        = ex_imme_r;
   assign ex_shamt       = ex_shamt_r;
   assign ex_alu_control = ex_alu_control_r;
   assign ex_alu_src     = ex_alu_src_r;
   assign ex_rd          = ex_rd_r;
   assign ex_reg_write   = ex_reg_write_r;
   assign ex_mem_read    = ex_mem_read_r;
   assign ex_mem_write   = ex_mem_write_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use bubble,
// hold/flush interaction, register zero and reset during hold.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, hold, flush, id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rs_data, id_rt_data;
   logic [15:0] id_imme;
   logic [4:0]  id_shamt;
   logic [3:0]  id_alu_control;
   logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
   logic [31:0] ex_alu_result;
   logic        mem_reg_write;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        load_use_stall, ex_valid;
   logic [31:0] ex_data_a, ex_data_b;
   logic [15:0] ex_imme;
   logic [4:0]  ex_shamt;
   logic [3:0]  ex_alu_control;
   logic        ex_alu_src;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imme(id_imme), .id_shamt(id_shamt), .id_alu_control(id_alu_control),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .ex_alu_result(ex_alu_result),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .load_use_stall(load_use_stall), .ex_valid(ex_valid),
      .ex_data_a(ex_data_a), .ex_data_b(ex_data_b), .ex_imme(ex_imme),
      .ex_shamt(ex_shamt), .ex_alu_control(ex_alu_control), .ex_alu_src(ex_alu_src),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rs_d,
                           input logic [31:0] rt_d, input logic [15:0] imm,
                           input logic [4:0] sh, input logic [3:0] alu, input logic src,
                           input logic rw, input logic mr, input logic mw);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rs_data = rs_d; id_rt_data = rt_d; id_imme = imm; id_shamt = sh;
      id_alu_control = alu; id_alu_src = src;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   task automatic set_idle();
      drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      ex_alu_result = 32'h0;
      mem_reg_write = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
      wb_reg_write  = 1'b0; wb_rd  = 5'd0; wb_data  = 32'h0;
   endtask

   initial begin
      rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
      set_idle();
      tick(); tick();
      rst_n = 1'b1;

      // Reset asserted mid-cycle with everything non-zero
      drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222, 16'h1234, 5'd5,
               4'h2, 1'b0, 1'b1, 1'b1, 1'b1);
      ex_alu_result = 32'hCAFE_0000;
      mem_reg_write = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999_9999;
      wb_reg_write  = 1'b1; wb_rd  = 5'd10; wb_data = 32'hAAAA_AAAA;
      tick(); tick();
      check_eq("pre_reset_valid", 32'(ex_valid), 32'h1);
      check_eq("pre_reset_data_a", ex_data_a, 32'h1111_1111);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_valid", 32'(ex_valid), 32'h0);
      check_eq("rst_data_a", ex_data_a, 32'h0);
      check_eq("rst_data_b", ex_data_b, 32'h0);
      check_eq("rst_imme", 32'(ex_imme), 32'h0);
      check_eq("rst_shamt", 32'(ex_shamt), 32'h0);
      check_eq("rst_alu", 32'(ex_alu_control), 32'h0);
      check_eq("rst_ctrl", 32'({ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write}), 32'h0);
      check_eq("rst_rd", 32'(ex_rd), 32'h0);
      check_eq("rst_stall", 32'(load_use_stall), 32'h0);
      set_idle();
      #2 rst_n = 1'b1;
      tick();

      // EX forwarding beats MEM
      drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 16'h0, 5'd0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      ex_alu_result = 32'h0000_0010;
      mem_reg_write = 1'b1; mem_rd = 5'd3; mem_data = 32'h0000_0020;
      drive_id(1'b1, 5'd3, 5'd2, 5'd5, 32'h5, 32'h7, 16'h0, 5'd0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_eq("ex_fwd_a", ex_data_a, 32'h0000_0010);
      check_eq("ex_fwd_b_none", ex_data_b, 32'h7);

      // Load-use: lw r4 then add rs=r4
      mem_reg_write = 1'b0;
      drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h0, 32'h0, 16'h0004, 5'd0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      drive_id(1'b1, 5'd4, 5'd2, 5'd5, 32'h0BAD, 32'h7, 16'h0, 5'd0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      check_eq("lu_stall", 32'(load_use_stall), 32'h1);
      tick();
      check_eq("lu_bubble_valid", 32'(ex_valid), 32'h0);
      check_eq("lu_bubble_rw", 32'(ex_reg_write), 32'h0);
      check_eq("lu_stall_clear", 32'(load_use_stall), 32'h0);
      mem_reg_write = 1'b1; mem_rd = 5'd4; mem_data = 32'hDEAD_BEEF;
      tick();
      check_eq("lu_mem_fwd", ex_data_a, 32'hDEAD_BEEF);
      check_eq("lu_valid", 32'(ex_valid), 32'h1);
      check_eq("lu_rd", 32'(ex_rd), 32'd5);

      // Load-use with rt used only as immediate-form destination
      mem_reg_write = 1'b0;
      drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h0, 32'h0, 16'h0004, 5'd0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      drive_id(1'b1, 5'd1, 5'd4, 5'd6, 32'h0, 32'h0, 16'h0001, 5'd0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      check_eq("lu_imm_nostall", 32'(load_use_stall), 32'h0);
      id_alu_src = 1'b0;
      #1;
      check_eq("lu_rt_stall", 32'(load_use_stall), 32'h1);
      id_alu_src = 1'b1; id_mem_write = 1'b1;
      #1;
      check_eq("lu_sw_stall", 32'(load_use_stall), 32'h1);
      id_valid = 1'b0;
      #1;
      check_eq("lu_invalid_nostall", 32'(load_use_stall), 32'h0);

      // Hold freezes, then flush overrides hold
      drive_id(1'b1, 5'd1, 5'd2, 5'd6, 32'h11, 32'h22, 16'hABCD, 5'd3, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_eq("cap_data_a", ex_data_a, 32'h11);
      check_eq("cap_imme", 32'(ex_imme), 32'h0000_ABCD);
      check_eq("cap_shamt", 32'(ex_shamt), 32'd3);
      check_eq("cap_alu", 32'(ex_alu_control), 32'h6);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_id(1'b1, 5'(i + 1), 5'(i + 2), 5'(i + 7), 32'(100 + i), 32'(200 + i),
                  16'(i), 5'(i), 4'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1);
         tick();
         check_eq("hold_data_a", ex_data_a, 32'h11);
         check_eq("hold_alu", 32'(ex_alu_control), 32'h6);
         check_eq("hold_rd", 32'(ex_rd), 32'd6);
      end
      flush = 1'b1;
      tick();
      check_eq("flush_valid", 32'(ex_valid), 32'h0);
      check_eq("flush_alu", 32'(ex_alu_control), 32'h0);
      check_eq("flush_ctrl", 32'({ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write}), 32'h0);
      check_eq("flush_data_a", ex_data_a, 32'h0);
      check_eq("flush_imme", 32'(ex_imme), 32'h0);
      hold = 1'b0; flush = 1'b0;

      // Register zero never forwards
      wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
      mem_reg_write = 1'b1; mem_rd = 5'd0; mem_data = 32'h55;
      drive_id(1'b1, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 16'h0, 5'd0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_eq("r0_data_a", ex_data_a, 32'h0);
      check_eq("r0_data_b", ex_data_b, 32'h0);

      // WB forward on rs, MEM on rt; then MEM beats WB
      mem_rd = 5'd7; mem_data = 32'h1;
      wb_rd  = 5'd8; wb_data  = 32'h2;
      drive_id(1'b1, 5'd8, 5'd7, 5'd10, 32'hAA, 32'hBB, 16'h0, 5'd0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_eq("wb_fwd_a", ex_data_a, 32'h2);
      check_eq("mem_fwd_b", ex_data_b, 32'h1);
      mem_rd = 5'd9; mem_data = 32'h33;
      wb_rd  = 5'd9; wb_data  = 32'h44;
      drive_id(1'b1, 5'd9, 5'd2, 5'd11, 32'hCC, 32'h77, 16'h0, 5'd0, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check_eq("mem_over_wb", ex_data_a, 32'h33);
      check_eq("no_fwd_b", ex_data_b, 32'h77);

      // Reset during hold clears the held slot
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      hold = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      check_eq("rst_hold_valid", 32'(ex_valid), 32'h0);
      check_eq("rst_hold_rd", 32'(ex_rd), 32'h0);
      hold = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
